// File: rtl/queue_ctrl_pkg.sv
// Shared types and constants for the queue control block: FSM state encoding,
// occupancy counter direction codes and the depth derivation helper.
package queue_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_PARTIAL = 2'b01,
    ST_FULL    = 2'b10
  } state_e;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Queue depth is always a power of two so pointers wrap naturally.
  function automatic int unsigned queue_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/queue_ctrl_if.sv
// Requester/storage-facing bundle of the queue controller. The controller uses
// the slave view; whoever drives push/pop/flush uses the master view.
interface queue_ctrl_if #(
  parameter int ADDR_W = 10
);

  logic              Flush;
  logic              WrReq;
  logic              RdReq;
  logic              WrAck;
  logic              RdAck;
  logic              MemWe;
  logic              MemRe;
  logic [ADDR_W-1:0] WrAddr;
  logic [ADDR_W-1:0] RdAddr;
  logic              RdValid;
  logic              CntEn;
  logic              CntDir;
  logic [ADDR_W:0]   Count;
  logic              Empty;
  logic              Full;
  logic              AlmostEmpty;
  logic              AlmostFull;
  logic              Ovf;
  logic              Udf;

  modport slave (
    input  Flush, WrReq, RdReq,
    output WrAck, RdAck, MemWe, MemRe, WrAddr, RdAddr, RdValid,
           CntEn, CntDir, Count, Empty, Full, AlmostEmpty, AlmostFull,
           Ovf, Udf
  );

  modport master (
    output Flush, WrReq, RdReq,
    input  WrAck, RdAck, MemWe, MemRe, WrAddr, RdAddr, RdValid,
           CntEn, CntDir, Count, Empty, Full, AlmostEmpty, AlmostFull,
           Ovf, Udf
  );

endinterface

// File: rtl/queue_ctrl_ptr.sv
// Wrapping ADDR_W-bit pointer: advances on Inc, clears synchronously on Clr,
// clears asynchronously on Rst. Used for both the write and read pointers.
module queue_ptr #(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Clr,
  input  logic              Inc,
  output logic [ADDR_W-1:0] Ptr
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  always_comb begin
    // NOTE: default assignment first so every path writes ptr_d and no latch is inferred.
    ptr_d = ptr_q;
    if (Clr) begin
      ptr_d = '0;
    end else if (Inc) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  // NOTE: non-blocking assignment for state so all flops update from pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign Ptr = ptr_q;

endmodule

// File: rtl/queue_ctrl.sv
// Queue control and sequencing: gates push/pop handshakes, owns pointers and
// occupancy, drives the occupancy counter controls and reports status flags.
module queue_ctrl
  import queue_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int AF_LVL = 1020,
  parameter int AE_LVL = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  queue_ctrl_if.slave  bus
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_CNT = CW'(queue_depth(ADDR_W));
  localparam logic [ADDR_W:0] LAST_CNT  = DEPTH_CNT - CW'(1);
  localparam logic [ADDR_W:0] ONE_CNT   = CW'(1);
  localparam logic [ADDR_W:0] AF_CNT    = CW'(AF_LVL);
  localparam logic [ADDR_W:0] AE_CNT    = CW'(AE_LVL);

  state_e          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            cnt_dir_q, cnt_dir_d;
  logic            rd_valid_q, rd_valid_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  logic            wr_ack, rd_ack;
  logic            wr_only, rd_only;
  logic            empty, full;

  // Acks are combinational but suppressed during reset and flush, and gated by
  // state alone so a same-cycle pop never frees room for a push (and vice versa).
  assign wr_ack  = ~Rst & ~bus.Flush & bus.WrReq & (state_q != ST_FULL);
  assign rd_ack  = ~Rst & ~bus.Flush & bus.RdReq & (state_q != ST_EMPTY);
  assign wr_only = wr_ack & ~rd_ack;
  assign rd_only = rd_ack & ~wr_ack;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DEPTH_CNT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cnt_dir_d  = cnt_dir_q;
    rd_valid_d = rd_ack;
    ovf_d      = ovf_q | (bus.WrReq & full);
    udf_d      = udf_q | (bus.RdReq & empty);

    if (wr_only) begin
      cnt_d     = cnt_q + ONE_CNT;
      cnt_dir_d = CNT_UP;
    end else if (rd_only) begin
      cnt_d     = cnt_q - ONE_CNT;
      cnt_dir_d = CNT_DN;
    end

    unique case (state_q)
      ST_EMPTY: begin
        if (wr_only) state_d = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (rd_only && cnt_q == ONE_CNT)       state_d = ST_EMPTY;
        else if (wr_only && cnt_q == LAST_CNT) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (rd_only) state_d = ST_PARTIAL;
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush returns everything to the reset state, overriding the updates above.
    if (bus.Flush) begin
      state_d    = ST_EMPTY;
      cnt_d      = '0;
      cnt_dir_d  = CNT_UP;
      rd_valid_d = 1'b0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_EMPTY;
      cnt_q      <= '0;
      cnt_dir_q  <= CNT_UP;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cnt_dir_q  <= cnt_dir_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  queue_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .Clk (Clk),
    .Rst (Rst),
    .Clr (bus.Flush),
    .Inc (wr_ack),
    .Ptr (bus.WrAddr)
  );

  queue_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .Clk (Clk),
    .Rst (Rst),
    .Clr (bus.Flush),
    .Inc (rd_ack),
    .Ptr (bus.RdAddr)
  );

  assign bus.WrAck       = wr_ack;
  assign bus.RdAck       = rd_ack;
  assign bus.MemWe       = wr_ack;
  assign bus.MemRe       = rd_ack;
  assign bus.CntEn       = wr_only | rd_only;
  assign bus.CntDir      = cnt_dir_d;
  assign bus.RdValid     = rd_valid_q;
  assign bus.Count       = cnt_q;
  assign bus.Empty       = empty;
  assign bus.Full        = full;
  assign bus.AlmostEmpty = (cnt_q <= AE_CNT);
  assign bus.AlmostFull  = (cnt_q >= AF_CNT);
  assign bus.Ovf         = ovf_q;
  assign bus.Udf         = udf_q;

  // The state register must always agree with the occupancy it summarises.
  a_cnt_bound: assert property (@(posedge Clk) disable iff (Rst) cnt_q <= DEPTH_CNT);
  a_empty_consistent: assert property (@(posedge Clk) disable iff (Rst)
    (state_q == ST_EMPTY) == (cnt_q == '0));
  a_full_consistent: assert property (@(posedge Clk) disable iff (Rst)
    (state_q == ST_FULL) == (cnt_q == DEPTH_CNT));

endmodule

// File: tb/tb_queue_ctrl.sv
// Scoreboard bench for queue_ctrl at ADDR_W = 4: directed stimulus pushes
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_queue_ctrl;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AF_LVL = 14;
  localparam int AE_LVL = 4;

  typedef struct {
    int cyc;
    bit wa;
    bit ra;
    int cnt;
    bit ovf;
    bit udf;
    int waddr;
    int raddr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   wptr_m = 0;
  int   rptr_m = 0;
  exp_t st_q[$];
  int   rdv_q[$];

  queue_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  queue_ctrl #(
    .ADDR_W (ADDR_W),
    .AF_LVL (AF_LVL),
    .AE_LVL (AE_LVL)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus plus the hand-computed response for that cycle.
  task automatic step(input bit wr, input bit rd, input bit fl,
                      input bit wa, input bit ra, input int cnt,
                      input bit ovf, input bit udf);
    exp_t e;
    @(posedge clk);
    #1;
    bus.WrReq = wr;
    bus.RdReq = rd;
    bus.Flush = fl;
    e.cyc = cyc; e.wa = wa; e.ra = ra; e.cnt = cnt;
    e.ovf = ovf; e.udf = udf; e.waddr = wptr_m; e.raddr = rptr_m;
    st_q.push_back(e);
    if (wa) wptr_m = (wptr_m + 1) % DEPTH;
    if (ra) begin
      rptr_m = (rptr_m + 1) % DEPTH;
      rdv_q.push_back(cyc + 1);
    end
    if (fl) begin
      wptr_m = 0;
      rptr_m = 0;
    end
  endtask

  // Monitor: inputs are stable from posedge+1, so negedge sees this cycle's acks.
  always @(negedge clk) begin
    exp_t e;
    while (st_q.size() > 0 && st_q[0].cyc < cyc) begin
      check("stale_expectation", st_q[0].cyc, cyc);
      void'(st_q.pop_front());
    end
    if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
      e = st_q.pop_front();
      check("wr_ack",       bus.WrAck,       e.wa);
      check("mem_we",       bus.MemWe,       e.wa);
      check("rd_ack",       bus.RdAck,       e.ra);
      check("mem_re",       bus.MemRe,       e.ra);
      check("cnt_en",       bus.CntEn,       e.wa ^ e.ra);
      if (e.wa ^ e.ra) check("cnt_dir", bus.CntDir, e.wa);
      check("count",        bus.Count,       e.cnt);
      check("wr_addr",      bus.WrAddr,      e.waddr);
      check("rd_addr",      bus.RdAddr,      e.raddr);
      check("empty",        bus.Empty,       e.cnt == 0);
      check("full",         bus.Full,        e.cnt == DEPTH);
      check("almost_empty", bus.AlmostEmpty, e.cnt <= AE_LVL);
      check("almost_full",  bus.AlmostFull,  e.cnt >= AF_LVL);
      check("ovf",          bus.Ovf,         e.ovf);
      check("udf",          bus.Udf,         e.udf);
    end
    if (bus.RdValid) begin
      if (rdv_q.size() == 0) check("rdvalid_unexpected", bus.RdValid, 1'b0);
      else                   check("rdvalid_cycle", cyc, rdv_q.pop_front());
    end else if (rdv_q.size() > 0 && rdv_q[0] <= cyc) begin
      check("rdvalid_missing", bus.RdValid, 1'b1);
      void'(rdv_q.pop_front());
    end
    if (!rst) check("count_bound", bus.Count <= DEPTH, 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.WrReq = 1'b0;
    bus.RdReq = 1'b0;
    bus.Flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle.
    repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0);

    // Fill to full; WrAddr walks 0..15 then wraps.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 1, 0, i, 0, 0);
    step(1, 0, 0, 0, 0, DEPTH, 0, 0);
    step(0, 0, 0, 0, 0, DEPTH, 1, 0);

    // Simultaneous push/pop at Full: only the pop is accepted.
    step(1, 1, 0, 0, 1, DEPTH, 1, 0);
    step(1, 0, 0, 1, 0, DEPTH - 1, 1, 0);

    // Drain and underflow.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 1, DEPTH - i, 1, 0);
    step(0, 1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);

    // Simultaneous push/pop at Empty: only the push is accepted.
    step(1, 1, 0, 1, 0, 0, 1, 1);
    for (int i = 1; i < 5; i++) step(1, 0, 0, 1, 0, i, 1, 1);

    // Simultaneous push/pop at Count = 5 for three cycles.
    repeat (3) step(1, 1, 0, 1, 1, 5, 1, 1);
    step(1, 0, 0, 1, 0, 5, 1, 1);
    step(1, 0, 0, 1, 0, 6, 1, 1);

    // Flush at Count = 7 with WrReq held.
    step(1, 0, 1, 0, 0, 7, 1, 1);
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);

    // Async reset between edges right after an accepted pop.
    step(0, 1, 0, 0, 1, 1, 0, 0);
    void'(rdv_q.pop_back());
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_rd_ack",  bus.RdAck,   1'b0);
    check("rst_mem_re",  bus.MemRe,   1'b0);
    check("rst_count",   bus.Count,   0);
    check("rst_empty",   bus.Empty,   1'b1);
    check("rst_wr_addr", bus.WrAddr,  0);
    check("rst_rd_addr", bus.RdAddr,  0);
    check("rst_rdvalid", bus.RdValid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.RdReq = 1'b0;
    wptr_m = 0;
    rptr_m = 0;

    // Normal operation resumes after reset.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", st_q.size() + rdv_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/queue_ctrl.md
Name: queue_ctrl

Overview:
- Control and sequencing block for the queue datapath.
- Owns the write pointer, read pointer and occupancy count, and drives the occupancy up/down counter's enable and direction controls.
- Gates requester handshakes, produces memory write/read strobes and addresses, and reports status flags.
- Sits between the push/pop requesters and the queue storage array.

Parameters:
- ADDR_W, 10, pointer width; queue depth = 2^ADDR_W entries.
- AF_LVL, 1020, AlmostFull asserts when Count >= AF_LVL.
- AE_LVL, 4, AlmostEmpty asserts when Count <= AE_LVL.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Flush  in  1  synchronous clear request.
- WrReq  in  1  push request from producer.
- RdReq  in  1  pop request from consumer.
- WrAck  out  1  push accepted this cycle (combinational).
- RdAck  out  1  pop accepted this cycle (combinational).
- MemWe  out  1  storage write strobe, equal to WrAck.
- MemRe  out  1  storage read strobe, equal to RdAck.
- WrAddr  out  ADDR_W  storage write address (current write pointer).
- RdAddr  out  ADDR_W  storage read address (current read pointer).
- RdValid  out  1  registered; storage read data valid this cycle.
- CntEn  out  1  occupancy counter enable.
- CntDir  out  1  occupancy counter direction; 1 = increment, 0 = decrement.
- Count  out  ADDR_W+1  current occupancy, 0..2^ADDR_W.
- Empty  out  1  Count == 0.
- Full  out  1  Count == 2^ADDR_W.
- AlmostEmpty  out  1  Count <= AE_LVL.
- AlmostFull  out  1  Count >= AF_LVL.
- Ovf  out  1  sticky: WrReq seen while Full.
- Udf  out  1  sticky: RdReq seen while Empty.

Behaviour:
- Reset (Rst high, async): pointers = 0, Count = 0, state = EMPTY, RdValid = 0, Ovf = Udf = 0.
  - Resulting outputs: Empty = 1, Full = 0, AlmostEmpty = 1, AlmostFull = 0.
  - Ack and strobe outputs are forced to 0 while Rst is high.
- FSM states: EMPTY, PARTIAL, FULL; state is registered and always consistent with Count.
- Accept rules (evaluated each cycle, Flush low):
  - WrAck = WrReq & (state != FULL).
  - RdAck = RdReq & (state != EMPTY).
  - In FULL, a simultaneous read does not enable the write; the write is rejected that cycle.
  - In EMPTY, a simultaneous write does not enable the read; no read-through.
- Pointer and count update on the clock edge:
  - WrAck: write pointer +1, mod 2^ADDR_W, natural wrap from 2^ADDR_W-1 to 0.
  - RdAck: read pointer +1, same wrap rule.
  - WrAck only: CntEn = 1, CntDir = 1, Count +1.
  - RdAck only: CntEn = 1, CntDir = 0, Count -1.
  - Both: CntEn = 0, Count unchanged; both pointers advance.
  - Neither: CntEn = 0; CntDir holds its previous value (don't-care).
- State transitions:
  - EMPTY -> PARTIAL on a write-only cycle.
  - PARTIAL -> EMPTY on a read-only cycle when Count == 1.
  - PARTIAL -> FULL on a write-only cycle when Count == 2^ADDR_W-1.
  - FULL -> PARTIAL on a read-only cycle.
  - Otherwise hold.
- Read latency: storage is synchronous-read. RdValid = RdAck registered, so it is high exactly one cycle after each accepted pop.
- Status flags: Empty, Full, AlmostEmpty and AlmostFull are decoded combinationally from registered Count and state; no extra latency beyond the Count update.
- Error flags:
  - Ovf sets on the edge where WrReq & Full; Udf sets on the edge where RdReq & Empty.
  - Both clear only on Rst or Flush.
- Flush (synchronous, highest priority below Rst):
  - On the edge with Flush high, the design returns to the full reset state, RdValid included.
  - WrAck, RdAck, MemWe, MemRe and CntEn are 0 during the Flush cycle, even if requests are present.
- Rst asserted mid-operation: immediate async return to the reset state; an in-flight RdValid is dropped.
- Count never exceeds 2^ADDR_W or goes below 0; the gating above guarantees this and the bench asserts it.

Decomposition:
- Shared package holds:
  - the state encoding typedef (EMPTY = 2'b00, PARTIAL = 2'b01, FULL = 2'b10);
  - CNT_UP = 1'b1 and CNT_DN = 1'b0 constants;
  - depth localparam derivation, DEPTH = 1 << ADDR_W.
- One natural sub-module, queue_ptr: ADDR_W-bit wrapping increment pointer with async Rst and sync Clr. It is instantiated twice, once for the write pointer and once for the read pointer.
- Occupancy tracking stays in queue_ctrl, paired with the emitted CntEn/CntDir.

Test Plan:
- Reset then idle: Rst pulse, then 5 idle cycles -> Count = 0, Empty = 1, Full = 0, AlmostEmpty = 1, all acks 0, WrAddr = RdAddr = 0.
- Fill to full (ADDR_W = 4): 16 consecutive WrReq -> all acked.
  - WrAddr walks 0..15 and wraps to 0; AlmostFull rises at Count >= AF_LVL.
  - Full = 1 at Count = 16; a 17th WrReq gives WrAck = 0 and Ovf = 1.
- Drain and underflow: from full, 16 RdReq -> RdAck each cycle, RdValid one cycle later each time.
  - Empty = 1 after the 16th pop; a 17th RdReq gives RdAck = 0 and Udf = 1.
- Simultaneous push/pop:
  - At Count = 5, WrReq = RdReq = 1 for 3 cycles -> Count stays 5, CntEn = 0, both pointers advance by 3.
  - At Full, the same stimulus -> only RdAck, Count = 15.
  - At Empty, the same stimulus -> only WrAck, Count = 1.
- Flush mid-traffic: at Count = 7 with WrReq held, pulse Flush -> the next cycle shows Count = 0, pointers 0, Ovf = Udf = 0 and RdValid = 0, with no ack during the Flush cycle.
- Async reset mid-read: assert Rst between clock edges right after RdAck -> outputs reach reset values before the next edge and RdValid never asserts.
